bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
- Accepts an unsigned binary value over a val/rdy input interface and returns packed BCD digits over a val/rdy output interface.
- It is the encode-side counterpart of the BCD-to-binary decode logic in the codes library, and feeds display and debug paths that need decimal digits.

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: binary request channel and BCD result channel.
interface bin2bcd_seq_if #(
    parameter int p_nbits   = 8,
    parameter int p_ndigits = 3
);
    logic                   in_val;
    logic                   in_rdy;
    logic [p_nbits-1:0]     in_;
    logic                   out_val;
    logic                   out_rdy;
    logic [4*p_ndigits-1:0] out;

    modport master (
        output in_val, in_, out_rdy,
        input  in_rdy, out_val, out
    );

    modport slave (
        input  in_val, in_, out_rdy,
        output in_rdy, out_val, out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift-and-add-3 step per cycle.
// All handshake outputs are registered; out is zero whenever out_val is low.
module bin2bcd_seq #(
    parameter int p_nbits   = 8,
    parameter int p_ndigits = 3
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  io
);
    localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;
    localparam int DW = 4 * p_ndigits;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [p_nbits-1:0]   bin_q, bin_d;
    logic [DW-1:0]        dig_q, dig_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 in_rdy_q, in_rdy_d;
    logic                 out_val_q, out_val_d;
    logic [DW-1:0]        out_q, out_d;
    logic [DW-1:0]        dig_adj_s;
    logic [DW+p_nbits-1:0] shift_s;

    // Digits are corrected independently; no carry crosses a digit boundary.
    function automatic logic [DW-1:0] add3_digits(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < p_ndigits; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = d[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Next-state and next-output computation for the converter FSM.
    always_comb begin
        dig_adj_s = add3_digits(dig_q);
        shift_s   = {dig_adj_s, bin_q} << 1'b1;
        state_d   = state_q;
        bin_d     = bin_q;
        dig_d     = dig_q;
        cnt_d     = cnt_q;
        in_rdy_d  = in_rdy_q;
        out_val_d = out_val_q;
        out_d     = out_q;
        case (state_q)
            IDLE: begin
                if (io.in_val) begin
                    state_d  = CALC;
                    bin_d    = io.in_;
                    dig_d    = {DW{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    in_rdy_d = 1'b0;
                end else begin
                    in_rdy_d  = 1'b1;
                    out_val_d = 1'b0;
                    out_d     = {DW{1'b0}};
                end
            end
            CALC: begin
                dig_d = shift_s[DW+p_nbits-1 -: DW];
                bin_d = shift_s[p_nbits-1:0];
                cnt_d = cnt_q + CW'(1'b1);
                if (cnt_q == CW'(p_nbits - 1)) begin
                    state_d   = DONE;
                    out_val_d = 1'b1;
                    out_d     = shift_s[DW+p_nbits-1 -: DW];
                end else begin
                    out_val_d = 1'b0;
                    out_d     = {DW{1'b0}};
                end
            end
            DONE: begin
                if (io.out_rdy) begin
                    state_d   = IDLE;
                    in_rdy_d  = 1'b1;
                    out_val_d = 1'b0;
                    out_d     = {DW{1'b0}};
                end else begin
                    state_d   = DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                in_rdy_d  = 1'b1;
                out_val_d = 1'b0;
                out_d     = {DW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= {p_nbits{1'b0}};
            dig_q     <= {DW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
            out_q     <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
            out_q     <= out_d;
        end
    end

    assign io.in_rdy  = in_rdy_q;
    assign io.out_val = out_val_q;
    assign io.out     = out_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: an 8-bit/3-digit instance and a 4-bit/2-digit instance.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.p_nbits(8), .p_ndigits(3)) bus8 ();
    bin2bcd_seq_if #(.p_nbits(4), .p_ndigits(2)) bus4 ();

    bin2bcd_seq #(.p_nbits(8), .p_ndigits(3)) dut8 (.clk(clk), .reset(reset), .io(bus8));
    bin2bcd_seq #(.p_nbits(4), .p_ndigits(2)) dut4 (.clk(clk), .reset(reset), .io(bus4));

    task automatic test_reset();
        reset = 1'b1;
        bus8.in_val = 1'b0; bus8.in_ = 8'd0; bus8.out_rdy = 1'b1;
        bus4.in_val = 1'b0; bus4.in_ = 4'd0; bus4.out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus8.in_rdy !== 1'b1 || bus8.out_val !== 1'b0 || bus8.out !== 12'h000) begin
            errors++;
            $display("FAIL reset8 in_rdy=%b out_val=%b out=%h expected 1 0 000", bus8.in_rdy, bus8.out_val, bus8.out);
        end
        checks++;
        if (bus4.in_rdy !== 1'b1 || bus4.out_val !== 1'b0 || bus4.out !== 8'h00) begin
            errors++;
            $display("FAIL reset4 in_rdy=%b out_val=%b out=%h expected 1 0 00", bus4.in_rdy, bus4.out_val, bus4.out);
        end
    endtask

    // One full conversion on the 8-bit instance with out_rdy high, checking latency and result.
    task automatic test_convert(input logic [7:0] v, input logic [11:0] exp);
        @(negedge clk);
        checks++;
        if (bus8.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL conv_rdy v=%0d in_rdy=%b expected 1", v, bus8.in_rdy);
        end
        bus8.in_val = 1'b1; bus8.in_ = v; bus8.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_val = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus8.out_val !== (k == 8) || (k < 8 && bus8.out !== 12'h000)) begin
                errors++;
                $display("FAIL conv_lat v=%0d k=%0d out_val=%b out=%h expected out_val=%b", v, k, bus8.out_val, bus8.out, (k == 8));
            end
        end
        checks++;
        if (bus8.out !== exp) begin
            errors++;
            $display("FAIL conv_out v=%0d out=%h expected %h", v, bus8.out, exp);
        end
        @(negedge clk);
        checks++;
        if (bus8.out_val !== 1'b0 || bus8.in_rdy !== 1'b1 || bus8.out !== 12'h000) begin
            errors++;
            $display("FAIL conv_after v=%0d out_val=%b in_rdy=%b out=%h expected 0 1 000", v, bus8.out_val, bus8.in_rdy, bus8.out);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  vin  [6];
        logic [11:0] vexp [6];
        vin  = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
        vexp = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
        for (int i = 0; i < 6; i++) test_convert(vin[i], vexp[i]);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        bus8.out_rdy = 1'b0; bus8.in_val = 1'b1; bus8.in_ = 8'd123;
        @(posedge clk);
        @(negedge clk);
        bus8.in_val = 1'b0;
        n = 0;
        while (bus8.out_val !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bp_latency cycles=%0d expected 8", n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus8.out_val !== 1'b1 || bus8.out !== 12'h123 || bus8.in_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold i=%0d out_val=%b out=%h in_rdy=%b expected 1 123 0", i, bus8.out_val, bus8.out, bus8.in_rdy);
            end
            @(negedge clk);
        end
        bus8.out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus8.in_rdy !== 1'b1 || bus8.out_val !== 1'b0 || bus8.out !== 12'h000) begin
            errors++;
            $display("FAIL bp_release in_rdy=%b out_val=%b out=%h expected 1 0 000", bus8.in_rdy, bus8.out_val, bus8.out);
        end
    endtask

    task automatic test_busy_ignored();
        @(negedge clk);
        bus8.in_val = 1'b1; bus8.in_ = 8'd42; bus8.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_ = 8'd200;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (k < 8) begin
                if (bus8.in_rdy !== 1'b0 || bus8.out_val !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_calc k=%0d in_rdy=%b out_val=%b expected 0 0", k, bus8.in_rdy, bus8.out_val);
                end
            end else begin
                if (bus8.out_val !== 1'b1 || bus8.out !== 12'h042 || bus8.in_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_result out_val=%b out=%h in_rdy=%b expected 1 042 0", bus8.out_val, bus8.out, bus8.in_rdy);
                end
                bus8.in_val = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus8.in_rdy !== 1'b1 || bus8.out_val !== 1'b0) begin
            errors++;
            $display("FAIL busy_after in_rdy=%b out_val=%b expected 1 0", bus8.in_rdy, bus8.out_val);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus8.in_val = 1'b1; bus8.in_ = 8'd77; bus8.out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_val = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus8.in_rdy !== 1'b1 || bus8.out_val !== 1'b0 || bus8.out !== 12'h000) begin
            errors++;
            $display("FAIL midreset in_rdy=%b out_val=%b out=%h expected 1 0 000", bus8.in_rdy, bus8.out_val, bus8.out);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus8.out_val !== 1'b0) begin
                errors++;
                $display("FAIL midreset_ghost i=%0d out_val=%b out=%h expected 0", i, bus8.out_val, bus8.out);
            end
        end
        test_convert(8'd5, 12'h005);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [3];
        logic [11:0] exps [3];
        int acc, outs, last_cyc;
        bit pending;
        vals = '{8'd1, 8'd128, 8'd250};
        exps = '{12'h001, 12'h128, 12'h250};
        acc = 0; outs = 0; last_cyc = 0; pending = 1'b0;
        @(negedge clk);
        bus8.out_rdy = 1'b1; bus8.in_val = 1'b1; bus8.in_ = vals[0];
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (pending) begin
                pending = 1'b0;
                if (acc < 3) bus8.in_ = vals[acc];
                else bus8.in_val = 1'b0;
            end
            if (bus8.out_val === 1'b1 && outs < 3) begin
                checks++;
                if (bus8.out !== exps[outs]) begin
                    errors++;
                    $display("FAIL b2b_out idx=%0d out=%h expected %h", outs, bus8.out, exps[outs]);
                end
                if (outs > 0) begin
                    checks++;
                    if (cyc - last_cyc != 10) begin
                        errors++;
                        $display("FAIL b2b_spacing idx=%0d gap=%0d expected 10", outs, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                outs++;
            end
            if (bus8.in_rdy === 1'b1 && bus8.in_val === 1'b1) begin
                acc++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        bus8.in_val = 1'b0;
        checks++;
        if (outs != 3) begin
            errors++;
            $display("FAIL b2b_count outputs=%0d expected 3", outs);
        end
    endtask

    task automatic test_sweep4();
        logic [7:0] exp;
        for (int v = 0; v < 16; v++) begin
            exp = 8'(((v / 10) << 4) | (v % 10));
            @(negedge clk);
            checks++;
            if (bus4.in_rdy !== 1'b1) begin
                errors++;
                $display("FAIL sweep4_rdy v=%0d in_rdy=%b expected 1", v, bus4.in_rdy);
            end
            bus4.in_val = 1'b1; bus4.in_ = 4'(v);
            @(posedge clk);
            @(negedge clk);
            bus4.in_val = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                checks++;
                if (bus4.out_val !== (k == 4)) begin
                    errors++;
                    $display("FAIL sweep4_lat v=%0d k=%0d out_val=%b expected %b", v, k, bus4.out_val, (k == 4));
                end
            end
            checks++;
            if (bus4.out !== exp) begin
                errors++;
                $display("FAIL sweep4_out v=%0d out=%h expected %h", v, bus4.out, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignored();
        test_reset_mid();
        test_back_to_back();
        test_sweep4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
